psum_ctrl: RTL and testbench
============================

PSUM_CTRL -- requirements
Module: psum_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 24, partial-sum width.
REQ-002 SHALL have parameter ADDR_W, default 5, scratchpad address width.
REQ-003 SHALL have parameter DEPTH, default 32, scratchpad entries (2**ADDR_W).
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cfg_valid  in  1  job configuration offered.
REQ-007 SHALL have port cfg_ready  out  1  configuration accepted this cycle when both high.
REQ-008 SHALL have port cfg_num_psum  in  ADDR_W  psum entries per pass minus 1.
REQ-009 SHALL have port cfg_num_acc  in  8  accumulation passes minus 1.
REQ-010 SHALL have port in_valid  in  1  product available.
REQ-011 SHALL have port in_ready  out  1  product accepted when both high.
REQ-012 SHALL have port in_data  in  DATA_W  signed product.
REQ-013 SHALL have port out_valid  out  1  drained psum available.
REQ-014 SHALL have port out_ready  in  1  downstream accepts psum.
REQ-015 SHALL have port out_data  out  DATA_W  drained psum.
REQ-016 SHALL have port spad_wen  out  1  scratchpad write enable.
REQ-017 SHALL have port spad_ren  out  1  scratchpad read enable, combinational-read scratchpad.
REQ-018 SHALL have port spad_addr  out  ADDR_W  scratchpad address.
REQ-019 SHALL have port spad_wdata  out  DATA_W  scratchpad write data.
REQ-020 SHALL have port spad_rdata  in  DATA_W  scratchpad read data, valid same cycle as spad_ren/spad_addr.
REQ-021 SHALL have port busy  out  1  job in progress.
REQ-022 SHALL have port done  out  1  one-cycle pulse after last drain handshake.
REQ-023 SHALL have port ovf  out  1  sticky signed-overflow flag for current job.

Function
REQ-024 SHALL implement FSM states IDLE, ACCUM, DRAIN; transitions IDLE->ACCUM on cfg handshake, ACCUM->DRAIN on last write of last pass, DRAIN->IDLE on last out handshake.
REQ-025 SHALL assert cfg_ready only in IDLE; on handshake latch N=cfg_num_psum+1, P=cfg_num_acc+1, clear ptr, pass and ovf.
REQ-026 SHALL assert in_ready only in ACCUM; out_valid only in DRAIN.
REQ-027 SHALL, on an in handshake, drive spad_addr=ptr, spad_wen=1 same cycle; pass 0: spad_wdata=in_data, spad_ren=0; pass>0: spad_ren=1, spad_wdata=spad_rdata+in_data (single-cycle read-modify-write, no stall).
REQ-028 SHALL keep spad_wen=0 and spad_ren=0 in cycles with no in handshake in ACCUM and in IDLE.
REQ-029 SHALL wrap addition modulo 2**DATA_W and set ovf when operands share sign and result sign differs; ovf holds until next cfg handshake.
REQ-030 SHALL increment ptr per in handshake; at ptr==N-1 wrap ptr to 0 and increment pass; at pass==P-1 and ptr==N-1 enter DRAIN with ptr=0.
REQ-031 SHALL in DRAIN drive spad_ren=1, spad_addr=ptr, out_data=spad_rdata, spad_wen=0; advance ptr per out handshake; hold ptr and out_data while out_ready=0.
REQ-032 SHALL pulse done for exactly one cycle, the cycle after the last out handshake, with state already IDLE.
REQ-033 SHALL assert busy in ACCUM and DRAIN only.
REQ-034 SHALL ignore cfg_valid outside IDLE and in_valid outside ACCUM.
REQ-035 SHALL support N=1 and P=1 (single write then single drain); N=DEPTH with ptr wrap 31->0.

Reset
REQ-036 SHALL on rst force IDLE, ptr=0, pass=0, ovf=0, done=0, busy=0, out_valid=0, in_ready=0, cfg_ready=0 during rst, spad_wen=0, spad_ren=0, spad_addr=0, spad_wdata=0, out_data=0.
REQ-037 SHALL abandon any job on reset mid-ACCUM or mid-DRAIN; scratchpad contents are not cleared, next job pass 0 overwrites them.

Structure
REQ-038 SHALL place FSM state enumeration and default widths in the shared PE package.
REQ-039 SHALL be a single module; scratchpad instantiated by parent, not inside psum_ctrl.

Verification
REQ-040 SHALL test N=4,P=1, inputs 1,2,3,4 -> drain 1,2,3,4, done one pulse, ovf=0.
REQ-041 SHALL test N=2,P=3, inputs 10,20,-1,-2,5,5 -> drain 14,23.
REQ-042 SHALL test DATA_W=24 pass1 add 0x7FFFFF+1 -> out 0x800000, ovf=1 until next cfg.
REQ-043 SHALL test DRAIN with out_ready low 3 cycles mid-drain -> out_data stable, no entry skipped or repeated.
REQ-044 SHALL test rst asserted mid-ACCUM then new job N=1,P=1 input 7 -> drain 7, stale data absent.
REQ-045 SHALL test N=32,P=2 all inputs 1 with random in_valid gaps -> 32 outputs of 2, spad_wen only on handshakes.

Source files
------------

// File: rtl/psum_ctrl_pkg.sv
// rtl/psum_ctrl_pkg.sv - shared PE package: default widths, FSM states, add helpers
package psum_ctrl_pkg;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 32;
  localparam int PASS_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } psum_state_t;

  // Two's-complement overflow: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/psum_ctrl.sv
// rtl/psum_ctrl.sv - partial-sum accumulate/drain controller for an external scratchpad
module psum_ctrl
  import psum_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_num_psum,
  input  logic [7:0]        cfg_num_acc,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              spad_wen,
  output logic              spad_ren,
  output logic [ADDR_W-1:0] spad_addr,
  output logic [DATA_W-1:0] spad_wdata,
  input  logic [DATA_W-1:0] spad_rdata,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  psum_state_t       state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] last_ptr;
  logic [PASS_W-1:0] pass;
  logic [PASS_W-1:0] last_pass;
  logic              ovf_r;
  logic              done_r;

  logic              cfg_fire;
  logic              in_fire;
  logic              out_fire;
  logic              accumulating;
  logic              ptr_at_end;
  logic [DATA_W-1:0] sum;
  logic              sum_ovf;

  // Handshake readiness follows the FSM state; cfg_ready is also held low during reset.
  assign cfg_ready = (state == ST_IDLE) && !rst;
  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_DRAIN);
  assign busy      = (state != ST_IDLE);
  assign done      = done_r;
  assign ovf       = ovf_r;

  assign cfg_fire = cfg_valid && cfg_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Pass 0 seeds the scratchpad; later passes read-modify-write the same entry.
  assign accumulating = (pass != '0);

  // Last entry of a pass, also capped at the physical end of the scratchpad.
  assign ptr_at_end = (ptr == last_ptr) || (ptr == ADDR_W'(DEPTH - 1));

  assign sum     = spad_rdata + in_data;
  assign sum_ovf = add_ovf(spad_rdata[DATA_W-1], in_data[DATA_W-1], sum[DATA_W-1]);

  // Scratchpad port: writes only on accepted products, reads for RMW passes and for draining.
  always_comb begin
    spad_wen   = 1'b0;
    spad_ren   = 1'b0;
    spad_addr  = '0;
    spad_wdata = '0;
    out_data   = '0;
    if (in_fire) begin
      spad_wen   = 1'b1;
      spad_ren   = accumulating;
      spad_addr  = ptr;
      spad_wdata = accumulating ? sum : in_data;
    end else if (state == ST_DRAIN) begin
      spad_ren  = 1'b1;
      spad_addr = ptr;
      out_data  = spad_rdata;
    end
  end

  // Job FSM: latch config, walk ptr/pass through accumulation, then drain every entry once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      last_ptr  <= '0;
      pass      <= '0;
      last_pass <= '0;
      ovf_r     <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_fire) begin
            last_ptr  <= cfg_num_psum;
            last_pass <= cfg_num_acc;
            ptr       <= '0;
            pass      <= '0;
            ovf_r     <= 1'b0;
            state     <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (in_fire) begin
            if (accumulating && sum_ovf) begin
              ovf_r <= 1'b1;
            end
            if (ptr_at_end) begin
              ptr <= '0;
              if (pass == last_pass) begin
                pass  <= '0;
                state <= ST_DRAIN;
              end else begin
                pass <= pass + 1'b1;
              end
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (out_fire) begin
            if (ptr_at_end) begin
              ptr    <= '0;
              state  <= ST_IDLE;
              done_r <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_ctrl.sv
// tb/tb_psum_ctrl.sv - self-checking bench for psum_ctrl with a behavioural scratchpad
module tb_psum_ctrl;

  localparam int DW = 24;
  localparam int AW = 5;
  localparam int LIMIT = 20000;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_num_psum;
  logic [7:0]    cfg_num_acc;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          spad_wen;
  logic          spad_ren;
  logic [AW-1:0] spad_addr;
  logic [DW-1:0] spad_wdata;
  logic [DW-1:0] spad_rdata;
  logic          busy;
  logic          done;
  logic          ovf;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] spad [32];

  always #5 clk = ~clk;

  assign spad_rdata = spad[spad_addr];

  always @(posedge clk) begin
    if (spad_wen) spad[spad_addr] <= spad_wdata;
  end

  psum_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_num_psum(cfg_num_psum), .cfg_num_acc(cfg_num_acc),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .spad_wen(spad_wen), .spad_ren(spad_ren), .spad_addr(spad_addr),
    .spad_wdata(spad_wdata), .spad_rdata(spad_rdata),
    .busy(busy), .done(done), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: each entry is the wrapped sum of its products over all passes;
  // overflow whenever an exact-integer running sum leaves the signed DW-bit range.
  function automatic void model(input int n, input int p, input logic [DW-1:0] d[$],
                                output logic [DW-1:0] exp[$], output bit ov);
    longint acc [32];
    longint s;
    logic [DW-1:0] t;
    exp = {};
    ov = 1'b0;
    for (int i = 0; i < n; i++) acc[i] = longint'($signed(d[i]));
    for (int k = 1; k < p; k++) begin
      for (int i = 0; i < n; i++) begin
        s = acc[i] + longint'($signed(d[k*n+i]));
        if (s > 64'sd8388607 || s < -64'sd8388608) ov = 1'b1;
        t = s[DW-1:0];
        acc[i] = longint'($signed(t));
      end
    end
    for (int i = 0; i < n; i++) begin
      t = acc[i][DW-1:0];
      exp.push_back(t);
    end
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_cfg_ready"}, cfg_ready, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_spad_wen"}, spad_wen, 0);
    chk({tag, "_spad_ren"}, spad_ren, 0);
    chk({tag, "_spad_addr"}, spad_addr, 0);
    chk({tag, "_spad_wdata"}, spad_wdata, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  task automatic run_job(input int n, input int p, input logic [DW-1:0] d[$],
                         input int gap_pct, input int stall_at, input int abort_after,
                         output logic [DW-1:0] outs[$]);
    int idx, cyc, got, stall_cnt, bad_acc, bad_drn;
    bit stall, have_held;
    logic [DW-1:0] held;
    outs = {};
    bad_acc = 0;
    bad_drn = 0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_num_psum = AW'(n - 1);
    cfg_num_acc = 8'(p - 1);
    #1;
    chk("cfg_ready_idle", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("ovf_clear_on_cfg", ovf, 0);
    chk("busy_accum", busy, 1);
    idx = 0;
    cyc = 0;
    while (idx < n * p && idx != abort_after && cyc < LIMIT) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data = d[idx];
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_num_psum = AW'($urandom);
      cfg_num_acc = 8'($urandom);
      #1;
      if (spad_wen !== in_valid || in_ready !== 1'b1 || cfg_ready !== 1'b0 || out_valid !== 1'b0)
        bad_acc++;
      if (in_valid) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    cfg_valid = 1'b0;
    if (idx == abort_after) return;
    chk("accum_in_budget", cyc < LIMIT, 1);
    chk("accum_protocol", bad_acc, 0);
    got = 0;
    cyc = 0;
    stall_cnt = 0;
    have_held = 1'b0;
    held = '0;
    while (got < n && cyc < LIMIT) begin
      stall = (got == stall_at) && (stall_cnt < 3);
      out_ready = !stall && ($urandom_range(0, 99) >= gap_pct);
      in_valid = 1'($urandom_range(0, 1));
      in_data = DW'($urandom);
      #1;
      if (out_valid !== 1'b1 || spad_wen !== 1'b0 || spad_ren !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0)
        bad_drn++;
      if (stall) stall_cnt++;
      if (have_held) chk("drain_hold", out_data, held);
      have_held = !out_ready;
      held = out_data;
      if (out_ready) begin
        outs.push_back(out_data);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("drain_in_budget", cyc < LIMIT, 1);
    chk("drain_protocol", bad_drn, 0);
    #1;
    chk("done_pulse", done, 1);
    chk("idle_after_drain", busy, 0);
    @(negedge clk);
    #1;
    chk("done_single", done, 0);
  endtask

  task automatic cmp_outs(input string tag, input logic [DW-1:0] act[$], input logic [DW-1:0] exp[$]);
    chk({tag, "_count"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++) chk({tag, "_data"}, act[i], exp[i]);
  endtask

  typedef struct {
    int n;
    int p;
    int stall_at;
    logic [DW-1:0] d[6];
    logic [DW-1:0] e[4];
    bit ov;
  } vec_t;

  initial begin
    vec_t vecs[4];
    logic [DW-1:0] dq[$];
    logic [DW-1:0] eq[$];
    logic [DW-1:0] outs[$];
    bit mov;
    int n, p;

    vecs[0].n = 4; vecs[0].p = 1; vecs[0].stall_at = -1;
    vecs[0].d = '{24'd1, 24'd2, 24'd3, 24'd4, 24'd0, 24'd0};
    vecs[0].e = '{24'd1, 24'd2, 24'd3, 24'd4};
    vecs[0].ov = 1'b0;
    vecs[1].n = 2; vecs[1].p = 3; vecs[1].stall_at = -1;
    vecs[1].d = '{24'd10, 24'd20, 24'hFFFFFF, 24'hFFFFFE, 24'd5, 24'd5};
    vecs[1].e = '{24'd14, 24'd23, 24'd0, 24'd0};
    vecs[1].ov = 1'b0;
    vecs[2].n = 4; vecs[2].p = 1; vecs[2].stall_at = 2;
    vecs[2].d = '{24'h123456, 24'hABCDEF, 24'h000777, 24'hFEDCBA, 24'd0, 24'd0};
    vecs[2].e = '{24'h123456, 24'hABCDEF, 24'h000777, 24'hFEDCBA};
    vecs[2].ov = 1'b0;
    vecs[3].n = 1; vecs[3].p = 2; vecs[3].stall_at = -1;
    vecs[3].d = '{24'h7FFFFF, 24'd1, 24'd0, 24'd0, 24'd0, 24'd0};
    vecs[3].e = '{24'h800000, 24'd0, 24'd0, 24'd0};
    vecs[3].ov = 1'b1;

    rst = 1'b1;
    cfg_valid = 1'b1;
    cfg_num_psum = '0;
    cfg_num_acc = '0;
    in_valid = 1'b1;
    in_data = 24'h55AA55;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk);
    rst = 1'b0;
    cfg_valid = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;

    foreach (vecs[v]) begin
      dq = {};
      eq = {};
      for (int i = 0; i < vecs[v].n * vecs[v].p; i++) dq.push_back(vecs[v].d[i]);
      for (int i = 0; i < vecs[v].n; i++) eq.push_back(vecs[v].e[i]);
      run_job(vecs[v].n, vecs[v].p, dq, 0, vecs[v].stall_at, -1, outs);
      cmp_outs($sformatf("vec%0d", v), outs, eq);
      chk($sformatf("vec%0d_ovf", v), ovf, vecs[v].ov);
    end
    repeat (3) @(negedge clk);
    #1;
    chk("ovf_sticky_idle", ovf, 1);

    dq = {};
    for (int i = 0; i < 8; i++) dq.push_back(24'd99);
    run_job(4, 2, dq, 0, -1, 3, outs);
    in_valid = 1'b1;
    cfg_valid = 1'b1;
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    cfg_valid = 1'b0;
    dq = {24'd7};
    eq = {24'd7};
    run_job(1, 1, dq, 0, -1, -1, outs);
    cmp_outs("after_rst", outs, eq);

    dq = {};
    eq = {};
    for (int i = 0; i < 64; i++) dq.push_back(24'd1);
    for (int i = 0; i < 32; i++) eq.push_back(24'd2);
    run_job(32, 2, dq, 40, -1, -1, outs);
    cmp_outs("full_depth", outs, eq);
    chk("full_depth_ovf", ovf, 0);

    for (int j = 0; j < 5; j++) begin
      n = $urandom_range(1, 32);
      p = $urandom_range(1, 4);
      dq = {};
      for (int i = 0; i < n * p; i++) begin
        if ($urandom_range(0, 2) == 0) dq.push_back(DW'($urandom));
        else dq.push_back(DW'($urandom_range(0, 2000)) - 24'd1000);
      end
      model(n, p, dq, eq, mov);
      run_job(n, p, dq, 30, $urandom_range(0, n - 1), -1, outs);
      cmp_outs($sformatf("rand%0d", j), outs, eq);
      chk($sformatf("rand%0d_ovf", j), ovf, mov);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
